// File: rtl/avaliador_notas_if.sv
// Board-side bundle of the grade evaluator: switch inputs towards the
// evaluator and its registered result/display outputs back.
interface avaliador_notas_if #(
    parameter int NBITS_NOTA = 4,
    parameter int N_NOTAS    = 4
);
    logic [NBITS_NOTA-1:0]          nota_in;
    logic                           enter;
    logic [7:0]                     SEG;
    logic [$clog2(N_NOTAS+1)-1:0]   contagem;
    logic [NBITS_NOTA-1:0]          media;
    logic                           done;
    logic                           erro;

    modport master (
        output nota_in, enter,
        input  SEG, contagem, media, done, erro
    );

    modport slave (
        input  nota_in, enter,
        output SEG, contagem, media, done, erro
    );
endinterface

// File: rtl/avaliador_notas.sv
// Grade evaluator: accumulates N_NOTAS switch grades confirmed by enter,
// then shows the floor-average verdict (A/F/P) or E on an illegal grade.
module avaliador_notas #(
    parameter int NBITS_NOTA = 4,
    parameter int N_NOTAS    = 4,
    parameter int NOTA_MAX   = 10,
    parameter int LIMIAR_A   = 7,
    parameter int LIMIAR_F   = 4
) (
    input  logic              clk_2,
    input  logic              reset,
    avaliador_notas_if.slave  bus
);
    localparam int W_CONT = $clog2(N_NOTAS + 1);
    localparam int W_SOMA = NBITS_NOTA + W_CONT;

    localparam logic [7:0] LETRA_A = 8'b0111_0111;
    localparam logic [7:0] LETRA_F = 8'b0111_0001;
    localparam logic [7:0] LETRA_P = 8'b0111_0011;
    localparam logic [7:0] LETRA_E = 8'b0111_1001;
    localparam logic [7:0] TRACO   = 8'b0100_0000;

    typedef enum logic [1:0] {COLETA, RESULTADO, ERRO} estado_t;

    estado_t             estado;
    logic                s1, s2, s3;
    logic                pulso;
    logic [W_SOMA-1:0]   soma;
    logic [W_SOMA-1:0]   soma_nova;
    logic [W_CONT-1:0]   contagem_nova;
    logic [NBITS_NOTA-1:0] media_nova;

    // enter is a raw switch: s1/s2 resynchronise it, s3 detects the rising edge.
    assign pulso         = s2 & ~s3;
    assign soma_nova     = soma + W_SOMA'(bus.nota_in);
    assign contagem_nova = bus.contagem + W_CONT'(1);
    assign media_nova    = NBITS_NOTA'(soma_nova / W_SOMA'(N_NOTAS));

    function automatic logic [7:0] letra(input logic [NBITS_NOTA-1:0] m);
        if (m >= NBITS_NOTA'(LIMIAR_A))      return LETRA_A;
        else if (m >= NBITS_NOTA'(LIMIAR_F)) return LETRA_F;
        else                                 return LETRA_P;
    endfunction

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_2) begin
        if (reset) begin
            estado       <= COLETA;
            s1           <= 1'b0;
            s2           <= 1'b0;
            s3           <= 1'b0;
            soma         <= '0;
            bus.contagem <= '0;
            bus.media    <= '0;
            bus.done     <= 1'b0;
            bus.erro     <= 1'b0;
            bus.SEG      <= TRACO;
        end else begin
            s1 <= bus.enter;
            s2 <= s1;
            s3 <= s2;
            case (estado)
                COLETA: begin
                    if (pulso) begin
                        if (bus.nota_in > NBITS_NOTA'(NOTA_MAX)) begin
                            estado   <= ERRO;
                            bus.erro <= 1'b1;
                            bus.SEG  <= LETRA_E;
                        end else begin
                            soma         <= soma_nova;
                            bus.contagem <= contagem_nova;
                            if (contagem_nova == W_CONT'(N_NOTAS)) begin
                                estado    <= RESULTADO;
                                bus.media <= media_nova;
                                bus.done  <= 1'b1;
                                bus.SEG   <= letra(media_nova);
                            end
                        end
                    end
                end
                RESULTADO: begin
                    if (pulso) begin
                        estado       <= COLETA;
                        soma         <= '0;
                        bus.contagem <= '0;
                        bus.media    <= '0;
                        bus.done     <= 1'b0;
                        bus.SEG      <= TRACO;
                    end
                end
                ERRO: begin
                    // The faulty evaluation is abandoned entirely, not resumed.
                    if (pulso) begin
                        estado       <= COLETA;
                        soma         <= '0;
                        bus.contagem <= '0;
                        bus.erro     <= 1'b0;
                        bus.SEG      <= TRACO;
                    end
                end
                default: estado <= COLETA;
            endcase
        end
    end
endmodule

// File: tb/tb_avaliador_notas.sv
// Self-checking bench for avaliador_notas: behavioural model compared every
// cycle, directed literal checks, randomised grade streams with resets.
module tb_avaliador_notas;
    localparam int NOTA_MAX = 10;
    localparam int N_NOTAS  = 4;
    localparam int LIMIAR_A = 7;
    localparam int LIMIAR_F = 4;

    localparam logic [7:0] LETRA_A = 8'b0111_0111;
    localparam logic [7:0] LETRA_F = 8'b0111_0001;
    localparam logic [7:0] LETRA_P = 8'b0111_0011;
    localparam logic [7:0] LETRA_E = 8'b0111_1001;
    localparam logic [7:0] TRACO   = 8'b0100_0000;

    logic clk_2 = 1'b0;
    logic reset = 1'b1;
    always #5 clk_2 = ~clk_2;

    avaliador_notas_if #(.NBITS_NOTA(4), .N_NOTAS(4)) b0 ();
    avaliador_notas_if #(.NBITS_NOTA(4), .N_NOTAS(3)) b1 ();

    avaliador_notas dut0 (.clk_2(clk_2), .reset(reset), .bus(b0.slave));

    avaliador_notas #(.NBITS_NOTA(4), .N_NOTAS(3), .NOTA_MAX(15),
                      .LIMIAR_A(7), .LIMIAR_F(4))
        dut1 (.clk_2(clk_2), .reset(reset), .bus(b1.slave));

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: grades accepted so far, running sum, verdict flags,
    // plus the last three sampled enter values (the synchroniser delay line).
    typedef struct packed {
        int count;
        int sum;
        int avg;
        bit done;
        bit err;
        bit h1;
        bit h2;
        bit h3;
    } model_t;

    model_t m = '0;

    function automatic model_t step(input model_t cur, input bit rst, input bit en, input int nota);
        model_t nx;
        bit pulse;
        nx = cur;
        if (rst) return model_t'(0);
        pulse = cur.h2 && !cur.h3;
        nx.h3 = cur.h2;
        nx.h2 = cur.h1;
        nx.h1 = en;
        if (pulse) begin
            if (cur.err) begin
                nx.err = 1'b0; nx.count = 0; nx.sum = 0;
            end else if (cur.done) begin
                nx.done = 1'b0; nx.count = 0; nx.sum = 0; nx.avg = 0;
            end else if (nota > NOTA_MAX) begin
                nx.err = 1'b1;
            end else begin
                nx.sum   = cur.sum + nota;
                nx.count = cur.count + 1;
                if (nx.count == N_NOTAS) begin
                    nx.done = 1'b1;
                    nx.avg  = nx.sum / N_NOTAS;
                end
            end
        end
        return nx;
    endfunction

    function automatic logic [7:0] exp_seg(input model_t s);
        if (s.err)                  return LETRA_E;
        if (!s.done)                return TRACO;
        if (s.avg >= LIMIAR_A)      return LETRA_A;
        if (s.avg >= LIMIAR_F)      return LETRA_F;
        return LETRA_P;
    endfunction

    always @(posedge clk_2)
        m <= step(m, reset, b0.enter, int'(b0.nota_in));

    always @(negedge clk_2) begin
        if (chk_en) begin
            check("model_seg",      32'(b0.SEG),      32'(exp_seg(m)));
            check("model_contagem", 32'(b0.contagem), m.count);
            check("model_media",    32'(b0.media),    m.avg);
            check("model_done",     32'(b0.done),     32'(m.done));
            check("model_erro",     32'(b0.erro),     32'(m.err));
        end
    end

    // Each task starts and ends just after a falling edge.
    task automatic grade0(input int nota, input int hold, input int gap);
        b0.nota_in = 4'(nota);
        b0.enter   = 1'b1;
        repeat (hold) @(negedge clk_2);
        b0.enter = 1'b0;
        repeat (gap) @(negedge clk_2);
    endtask

    task automatic grade1(input int nota);
        b1.nota_in = 4'(nota);
        b1.enter   = 1'b1;
        repeat (3) @(negedge clk_2);
        b1.enter = 1'b0;
        repeat (3) @(negedge clk_2);
    endtask

    task automatic expect_result(input string tag, input int med, input logic [7:0] seg);
        check({tag, "_done"},  32'(b0.done),  1);
        check({tag, "_media"}, 32'(b0.media), med);
        check({tag, "_seg"},   32'(b0.SEG),   32'(seg));
    endtask

    int seq_a [4] = '{8, 9, 7, 6};
    int seq_b [4] = '{7, 7, 7, 6};
    int seq_c [4] = '{2, 3, 1, 0};
    int seq_d [4] = '{10, 10, 9, 8};

    initial begin
        b0.nota_in = '0; b0.enter = 1'b0;
        b1.nota_in = '0; b1.enter = 1'b0;
        repeat (2) @(negedge clk_2);
        chk_en = 1'b1;
        check("rst_seg",      32'(b0.SEG),      32'(TRACO));
        check("rst_contagem", 32'(b0.contagem), 0);
        check("rst_done",     32'(b0.done),     0);
        check("rst_erro",     32'(b0.erro),     0);
        reset = 1'b0;
        @(negedge clk_2);

        for (int i = 0; i < 4; i++) begin
            grade0(seq_a[i], 3, 3);
            check("a_contagem", 32'(b0.contagem), i + 1);
        end
        expect_result("a", 7, LETRA_A);
        grade0(0, 3, 3);
        check("a_clear_done", 32'(b0.done), 0);
        check("a_clear_seg",  32'(b0.SEG),  32'(TRACO));

        for (int i = 0; i < 4; i++) grade0(seq_b[i], 3, 3);
        expect_result("b", 6, LETRA_F);
        grade0(0, 3, 3);
        for (int i = 0; i < 4; i++) grade0(seq_c[i], 3, 3);
        expect_result("c", 1, LETRA_P);
        grade0(0, 3, 3);

        grade0(5, 3, 3);
        grade0(12, 3, 3);
        check("e_erro",     32'(b0.erro),     1);
        check("e_seg",      32'(b0.SEG),      32'(LETRA_E));
        check("e_contagem", 32'(b0.contagem), 1);
        grade0(0, 3, 3);
        check("e_clr_contagem", 32'(b0.contagem), 0);
        check("e_clr_seg",      32'(b0.SEG),      32'(TRACO));
        check("e_clr_erro",     32'(b0.erro),     0);

        b0.nota_in = 4'd3;
        b0.enter   = 1'b1;
        repeat (2) @(negedge clk_2);
        check("hold_latency_before", 32'(b0.contagem), 0);
        @(negedge clk_2);
        check("hold_latency_at", 32'(b0.contagem), 1);
        repeat (47) @(negedge clk_2);
        check("hold_single", 32'(b0.contagem), 1);
        b0.enter = 1'b0;
        repeat (3) @(negedge clk_2);

        grade0(6, 3, 3);
        check("pre_rst_contagem", 32'(b0.contagem), 2);
        b0.nota_in = 4'd4;
        b0.enter   = 1'b1;
        repeat (2) @(negedge clk_2);
        reset = 1'b1;
        @(negedge clk_2);
        reset    = 1'b0;
        b0.enter = 1'b0;
        check("rp_contagem", 32'(b0.contagem), 0);
        check("rp_seg",      32'(b0.SEG),      32'(TRACO));
        check("rp_media",    32'(b0.media),    0);
        check("rp_done",     32'(b0.done),     0);
        check("rp_erro",     32'(b0.erro),     0);
        repeat (3) @(negedge clk_2);
        for (int i = 0; i < 4; i++) grade0(seq_d[i], 3, 3);
        expect_result("d", 9, LETRA_A);
        grade0(0, 3, 3);

        for (int i = 0; i < 3; i++) begin
            grade1(15);
            check("n3_contagem", 32'(b1.contagem), i + 1);
        end
        check("n3_done",  32'(b1.done),  1);
        check("n3_media", 32'(b1.media), 15);
        check("n3_seg",   32'(b1.SEG),   32'(LETRA_A));
        check("n3_erro",  32'(b1.erro),  0);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b1;
                @(negedge clk_2);
                reset = 1'b0;
            end
            grade0(int'($urandom_range(0, 15)), int'($urandom_range(1, 5)),
                   int'($urandom_range(2, 5)));
        end
        repeat (4) @(negedge clk_2);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/avaliador_notas.md
# avaliador_notas

Parametrised grade evaluator for the board top level. It collects `N_NOTAS` grades entered one at a time on the switches, confirmed by an `enter` switch. It then computes the floor average and shows the verdict letter on the seven-segment display (A = aprovado, F = final, P = reprovado). It replaces single-grade combinational classification with a sequential accumulate/average/classify flow, and adds error detection for out-of-range grades.

## Interface
Parameters:
- `NBITS_NOTA`, 4: width of one grade.
- `N_NOTAS`, 4: number of grades per evaluation, ≥1.
- `NOTA_MAX`, 10: largest legal grade.
- `LIMIAR_A`, 7: average ≥ this shows letter A.
- `LIMIAR_F`, 4: average ≥ this, and < `LIMIAR_A`, shows letter F.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk_2`  in  1  board clock.
  - `reset`  in  1  synchronous, active-high reset.
- `nota_in`  in  `NBITS_NOTA`  grade on the switches; must be stable while `enter` is being confirmed.
- `enter`  in  1  raw switch, asynchronous to `clk_2`; a rising edge confirms one entry.
- `SEG`  out  8  seven-segment pattern, registered. Bit 0 = segment a … bit 6 = segment g, bit 7 = dp.
- `contagem`  out  `$clog2(N_NOTAS+1)`  grades accepted so far, registered.
- `media`  out  `NBITS_NOTA`  floor average, registered; valid when `done`.
- `done`  out  1  result valid.
- `erro`  out  1  out-of-range grade detected.

## Operation
Encodings:
- LETRA_A = 01110111
- LETRA_F = 01110001
- LETRA_P = 01110011
- LETRA_E = 01111001
- TRACO = 01000000 (segment g only)

Input conditioning:
- `enter` passes through a 2-flop synchroniser `s1`→`s2`, then one edge flop `s3`.
- `pulso = s2 & ~s3`.
- Holding `enter` high produces exactly one `pulso`.

Arithmetic:
- Accumulator `soma` is `NBITS_NOTA + $clog2(N_NOTAS+1)` bits wide and cannot overflow for legal grades.
- Average: `media = (soma + nota_in) / N_NOTAS`, unsigned, truncated (floor). It is computed on the accepting cycle and registered on entry to RESULTADO.

FSM states: COLETA, RESULTADO, ERRO.
- COLETA:
  - `SEG` = TRACO, `done`=0, `erro`=0.
  - On `pulso` with `nota_in > NOTA_MAX`: go to ERRO; `soma` and `contagem` are unchanged.
  - On `pulso` with a legal grade: `soma += nota_in`, `contagem += 1`.
  - If that acceptance makes `contagem == N_NOTAS`: go to RESULTADO and register `media`.
- RESULTADO:
  - `done`=1.
  - `SEG` = LETRA_A if `media ≥ LIMIAR_A`; else LETRA_F if `media ≥ LIMIAR_F`; else LETRA_P.
  - On `pulso`: clear `soma`, `contagem`, `media`; go to COLETA. `nota_in` is ignored.
- ERRO:
  - `erro`=1, `SEG` = LETRA_E.
  - On `pulso`: clear `soma` and `contagem`; go to COLETA. The whole evaluation restarts.
- Without `pulso`, every state holds.

Reset:
- Returns to COLETA.
- Values: `SEG`=TRACO, `contagem`=0, `media`=0, `done`=0, `erro`=0, `soma`=0, `s1`/`s2`/`s3`=0.
- Reset overrides a simultaneous `pulso`.
- Reset mid-collection discards all partial grades.

## Timing
- `enter` rising before edge k: `s1`=1 after k, `s2`=1 after k+1, `pulso` high during cycle k+1→k+2.
- The grade is acted on at edge k+2, where `nota_in` is sampled. All outputs reflect it right after k+2, so latency from `enter` to outputs is 3 edges.
- `pulso` is exactly one cycle wide. A new confirmation needs `enter` low for at least 2 cycles, then high again.
- `done`/`erro`/`SEG` change only at the edge that performs a state transition, or at reset.

## Test plan
- Default parameters, grades 8, 9, 7, 6 → `contagem` steps 1..4; after the 4th acceptance `done`=1, `media`=7, `SEG`=01110111.
- Grades 7, 7, 7, 6 (sum 27) → `media`=6 (floor), `SEG`=01110001. Grades 2, 3, 1, 0 → `media`=1, `SEG`=01110011.
- Grades 5, then 12 → `erro`=1, `SEG`=01111001, `contagem`=1. Next `enter` → COLETA, `contagem`=0, `SEG`=01000000.
- `enter` held high for 50 cycles with `nota_in`=3 → exactly one acceptance (`contagem`=1). The first acceptance appears 3 edges after the `enter` rise.
- Two grades accepted, then `reset`=1 for one cycle concurrent with `pulso` → all outputs at reset values, grade not counted. A following 4-grade sequence evaluates normally.
- `N_NOTAS`=3, `NOTA_MAX`=15, `NBITS_NOTA`=4, grades 15, 15, 15 → no overflow, `media`=15, letter A.
